fp8_unpack_pipe: RTL and testbench

- Multi-lane, pipelined FP8-to-FP32 widener.
- Each beat carries LANES FP8 values plus a per-beat format select: E4M3 (bias 7) or E5M2 (bias 15).
- Results are returned with a valid/ready handshake.
- Sits between the FP8 operand buffers and the FP32 accumulate path of the MAC array. Also keeps saturating per-class event counters for debug.

---
 rtl/fp8_unpack_pipe.sv | 190 +++++++++++++++++++
 tb/tb_fp8_unpack_pipe.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp8_unpack_pipe.sv
// Two-stage FP8 (E4M3/E5M2) to FP32 widener with valid/ready handshake and
// saturating NaN/subnormal counters. Define FP8_OCP_E4M3_EN for OCP FN E4M3 specials.
module fp8_unpack_pipe #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_fmt,
  input  logic [8*LANES-1:0]    in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*LANES-1:0]   out_data,
  output logic [CNT_W-1:0]      nan_cnt,
  output logic [CNT_W-1:0]      sub_cnt,
  input  logic                  clr_cnt
);

  localparam logic [2:0] CL_ZERO = 3'd0;
  localparam logic [2:0] CL_SUB  = 3'd1;
  localparam logic [2:0] CL_NORM = 3'd2;
  localparam logic [2:0] CL_INF  = 3'd3;
  localparam logic [2:0] CL_NAN  = 3'd4;

  logic                   v1_q, v1_d, v2_q, v2_d, adv1;
  logic                   fmt_q, fmt_d;
  logic [LANES-1:0]       sgn_q, sgn_d;
  logic [LANES-1:0][4:0]  exp_q, exp_d;
  logic [LANES-1:0][2:0]  man_q, man_d;
  logic [LANES-1:0][2:0]  cls_q, cls_d;
  logic [LANES-1:0][1:0]  pos_q, pos_d;
  logic [32*LANES-1:0]    data_q, data_d;
  logic [4:0]             nanb_q, nanb_d, subb_q, subb_d;
  logic [CNT_W-1:0]       nan_cnt_q, nan_cnt_d, sub_cnt_q, sub_cnt_d;
  logic [CNT_W:0]         nan_sum, sub_sum;

  assign adv1      = !v2_q || out_ready;
  assign in_ready  = !v1_q || adv1;
  assign out_valid = v2_q;
  assign out_data  = data_q;
  assign nan_cnt   = nan_cnt_q;
  assign sub_cnt   = sub_cnt_q;

  always_comb begin : s1_decode
    logic [7:0] b;
    logic [4:0] e;
    logic [2:0] m;
    logic       emax;
    v1_d  = in_ready ? in_valid : v1_q;
    sgn_d = sgn_q;
    exp_d = exp_q;
    man_d = man_q;
    cls_d = cls_q;
    pos_d = pos_q;
    fmt_d = fmt_q;
    b = 8'h00;
    e = 5'd0;
    m = 3'd0;
    emax = 1'b0;
    if (in_ready && in_valid) begin
      fmt_d = in_fmt;
      for (int i = 0; i < LANES; i++) begin
        b    = in_data[8*i +: 8];
        e    = in_fmt ? b[6:2] : {1'b0, b[6:3]};
        m    = in_fmt ? {1'b0, b[1:0]} : b[2:0];
        emax = in_fmt ? (e == 5'h1F) : (e == 5'h0F);
        sgn_d[i] = b[7];
        exp_d[i] = e;
        man_d[i] = m;
        pos_d[i] = m[2] ? 2'd2 : (m[1] ? 2'd1 : 2'd0);
        if (e == 5'd0) begin
          cls_d[i] = (m == 3'd0) ? CL_ZERO : CL_SUB;
        end else if (emax) begin
`ifdef FP8_OCP_E4M3_EN
          // OCP FN E4M3 has no infinity; only mantissa 111 is NaN at max exponent
          if (!in_fmt) begin
            cls_d[i] = (m == 3'd7) ? CL_NAN : CL_NORM;
          end else begin
            cls_d[i] = (m == 3'd0) ? CL_INF : CL_NAN;
          end
`else
          cls_d[i] = (m == 3'd0) ? CL_INF : CL_NAN;
`endif
        end else begin
          cls_d[i] = CL_NORM;
        end
      end
    end else begin
      fmt_d = fmt_q;
    end
  end

  always_comb begin : s2_assemble
    logic [7:0]  ex;
    logic [22:0] fr;
    logic [4:0]  nn, ss;
    v2_d   = adv1 ? v1_q : v2_q;
    data_d = data_q;
    nanb_d = nanb_q;
    subb_d = subb_q;
    ex = 8'h00;
    fr = 23'h0;
    nn = 5'd0;
    ss = 5'd0;
    if (adv1 && v1_q) begin
      for (int i = 0; i < LANES; i++) begin
        ex = 8'h00;
        fr = 23'h0;
        case (cls_q[i])
          CL_ZERO: fr = 23'h0;
          CL_SUB: begin
            // value = man * 2^(1-B-M); renormalise around the leading one at pos
            ex = (fmt_q ? 8'd111 : 8'd118) + {6'd0, pos_q[i]};
            case (pos_q[i])
              2'd2:    fr = {man_q[i][1:0], 21'h0};
              2'd1:    fr = {man_q[i][0], 22'h0};
              default: fr = 23'h0;
            endcase
          end
          CL_INF: ex = 8'hFF;
          CL_NAN: begin
            ex = 8'hFF;
            fr = 23'h400000;
          end
          default: begin
            ex = {3'd0, exp_q[i]} + (fmt_q ? 8'd112 : 8'd120);
            fr = fmt_q ? {man_q[i][1:0], 21'h0} : {man_q[i], 20'h0};
          end
        endcase
        data_d[32*i +: 32] = {sgn_q[i], ex, fr};
        nn = nn + {4'd0, (cls_q[i] == CL_NAN)};
        ss = ss + {4'd0, (cls_q[i] == CL_SUB)};
      end
      nanb_d = nn;
      subb_d = ss;
    end else begin
      nanb_d = nanb_q;
    end
  end

  always_comb begin
    nan_sum = {1'b0, nan_cnt_q} + {{(CNT_W-4){1'b0}}, nanb_q};
    sub_sum = {1'b0, sub_cnt_q} + {{(CNT_W-4){1'b0}}, subb_q};
    if (clr_cnt) begin
      nan_cnt_d = '0;
      sub_cnt_d = '0;
    end else if (v2_q && out_ready) begin
      nan_cnt_d = nan_sum[CNT_W] ? '1 : nan_sum[CNT_W-1:0];
      sub_cnt_d = sub_sum[CNT_W] ? '1 : sub_sum[CNT_W-1:0];
    end else begin
      nan_cnt_d = nan_cnt_q;
      sub_cnt_d = sub_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      fmt_q     <= 1'b0;
      sgn_q     <= '0;
      exp_q     <= '0;
      man_q     <= '0;
      cls_q     <= '0;
      pos_q     <= '0;
      data_q    <= '0;
      nanb_q    <= 5'd0;
      subb_q    <= 5'd0;
      nan_cnt_q <= '0;
      sub_cnt_q <= '0;
    end else begin
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      fmt_q     <= fmt_d;
      sgn_q     <= sgn_d;
      exp_q     <= exp_d;
      man_q     <= man_d;
      cls_q     <= cls_d;
      pos_q     <= pos_d;
      data_q    <= data_d;
      nanb_q    <= nanb_d;
      subb_q    <= subb_d;
      nan_cnt_q <= nan_cnt_d;
      sub_cnt_q <= sub_cnt_d;
    end
  end

endmodule

// File: tb/tb_fp8_unpack_pipe.sv
// Randomised bench for fp8_unpack_pipe against a value-level FP8->FP32 model
// with a beat queue for ordering, latency and back-pressure.
module tb_fp8_unpack_pipe;
  localparam int LANES = 4;
  localparam int CMAX  = 65535;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_fmt, out_valid, out_ready, clr_cnt;
  logic [8*LANES-1:0]  in_data;
  logic [32*LANES-1:0] out_data;
  logic [15:0] nan_cnt, sub_cnt;

  fp8_unpack_pipe #(.LANES(LANES), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .nan_cnt(nan_cnt),
    .sub_cnt(sub_cnt), .clr_cnt(clr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [32*LANES-1:0] w;
    int nan;
    int sub;
    int enter;
  } beat_t;

  beat_t q[$];
  int total = 0, bad = 0, cyc = 0, mnan = 0, msub = 0;
  bit last_acc;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Value-level reference: significand * 2^k, then renormalise into FP32
  function automatic logic [31:0] ref_fp(input logic f, input logic [7:0] b);
    int ew, mw, bias, emax, e, m, sig, k, qb, ex, fr;
    logic s, special;
    logic [31:0] r;
    ew = f ? 5 : 4;
    mw = f ? 2 : 3;
    bias = (1 << (ew - 1)) - 1;
    emax = (1 << ew) - 1;
    s = b[7];
    e = int'(b[6:0]) >> mw;
    m = int'(b) & ((1 << mw) - 1);
    special = (e == emax);
`ifdef FP8_OCP_E4M3_EN
    if (!f) special = (e == emax) && (m == 7);
`endif
    if (special) begin
      r = (m == 0) ? {s, 8'hFF, 23'h0} : {s, 8'hFF, 23'h400000};
    end else if (e == 0 && m == 0) begin
      r = {s, 31'h0};
    end else begin
      if (e == 0) begin sig = m; k = 1 - bias - mw; end
      else begin sig = (1 << mw) | m; k = e - bias - mw; end
      qb = 0;
      for (int j = 0; j < 8; j++) if ((sig >> j) != 0) qb = j;
      ex = qb + k + 127;
      fr = (sig << (23 - qb)) & 32'h007FFFFF;
      r = {s, ex[7:0], fr[22:0]};
    end
    return r;
  endfunction

  function automatic beat_t make_beat(input logic f, input logic [8*LANES-1:0] d);
    beat_t bt;
    logic [31:0] w;
    logic [7:0] b;
    bt.nan = 0; bt.sub = 0; bt.w = '0; bt.enter = 0;
    for (int i = 0; i < LANES; i++) begin
      b = d[8*i +: 8];
      w = ref_fp(f, b);
      bt.w[32*i +: 32] = w;
      if (w[30:23] == 8'hFF && w[22:0] != 23'h0) bt.nan++;
      if ((f ? (b[6:2] == 5'd0) : (b[6:3] == 4'd0)) && (f ? (b[1:0] != 2'd0) : (b[2:0] != 3'd0))) bt.sub++;
    end
    return bt;
  endfunction

  // One clock: check outputs at the negedge, advance the model, return #1 after posedge
  task automatic cycle();
    bit eir, eov, pop, acc;
    beat_t nb;
    @(negedge clk);
    eir = !(q.size() == 2 && !out_ready);
    eov = (q.size() > 0) && (cyc >= q[0].enter);
    chk("in_ready", in_ready, eir);
    chk("out_valid", out_valid, eov);
    if (eov) chk("out_data", out_data, q[0].w);
    chk("nan_cnt", nan_cnt, mnan);
    chk("sub_cnt", sub_cnt, msub);
    last_acc = 1'b0;
    if (rst) begin
      q.delete();
      mnan = 0;
      msub = 0;
    end else begin
      pop = eov && out_ready;
      acc = in_valid && eir;
      if (clr_cnt) begin
        mnan = 0; msub = 0;
      end else if (pop) begin
        mnan = (mnan + q[0].nan > CMAX) ? CMAX : mnan + q[0].nan;
        msub = (msub + q[0].sub > CMAX) ? CMAX : msub + q[0].sub;
      end
      if (pop) begin
        void'(q.pop_front());
        if (q.size() > 0 && q[0].enter < cyc + 1) q[0].enter = cyc + 1;
      end
      if (acc) begin
        nb = make_beat(in_fmt, in_data);
        nb.enter = cyc + 2;
        q.push_back(nb);
        last_acc = 1'b1;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send_known(input string tag, input logic f, input logic [31:0] d,
                            input logic [127:0] expw);
    int lat;
    in_valid = 1'b1; in_fmt = f; in_data = d; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin cycle(); lat++; end
    chk({tag, "_lat"}, lat, 2);
    chk({tag, "_data"}, out_data, expw);
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while (q.size() > 0 && n < 20) begin cycle(); n++; end
    chk("drain", q.size(), 0);
  endtask

  function automatic logic [7:0] nan_byte(input logic f);
    logic [1:0] m;
    m = 2'($urandom_range(1, 3));
    return f ? {1'($urandom), 5'h1F, m} : {1'($urandom), 7'h7F};
  endfunction

  initial begin
    int sent, n;
    rst = 1'b1; in_valid = 1'b0; in_fmt = 1'b0; in_data = '0; out_ready = 1'b1; clr_cnt = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_data", out_data, 0);
    chk("rst_ov", out_valid, 0);

    send_known("e4m3", 1'b0, 32'h7F800138, {32'h7FC00000, 32'h80000000, 32'h3B000000, 32'h3F800000});
    cycle();
    chk("t1_nan", nan_cnt, 1);
    chk("t1_sub", sub_cnt, 1);

    send_known("e5m2", 1'b1, 32'h017D7C3C, {32'h37800000, 32'h7FC00000, 32'h7F800000, 32'h3F800000});
    cycle();
`ifdef FP8_OCP_E4M3_EN
    send_known("ocp", 1'b0, 32'h00007E78, {32'h0, 32'h0, 32'h43E00000, 32'h43800000});
`else
    send_known("ieee", 1'b0, 32'h00007E78, {32'h0, 32'h0, 32'h7FC00000, 32'h7F800000});
`endif
    // NaN beat transfers in the same cycle as a counter clear
    clr_cnt = 1'b1;
    cycle();
    clr_cnt = 1'b0;
    chk("clr_nan", nan_cnt, 0);
    chk("clr_sub", sub_cnt, 0);

    sent = 0; n = 0;
    while (sent < 8 && n < 200) begin
      in_valid = 1'b1; in_fmt = sent[0]; in_data = $urandom; out_ready = 1'($urandom);
      cycle();
      if (last_acc) sent++;
      n++;
    end
    chk("bp_sent", sent, 8);
    in_valid = 1'b0; n = 0;
    while (q.size() > 0 && n < 100) begin out_ready = 1'($urandom); cycle(); n++; end
    chk("bp_drain", q.size(), 0);

    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_fmt = 1'($urandom);
      in_data = $urandom;
      out_ready = ($urandom_range(0, 9) < 6);
      clr_cnt = ($urandom_range(0, 19) == 0);
      cycle();
    end
    clr_cnt = 1'b0;
    drain();

    // Saturate nan_cnt with all-NaN beats
    out_ready = 1'b1;
    for (int i = 0; i < 16400; i++) begin
      in_valid = 1'b1;
      in_fmt = 1'($urandom);
      for (int l = 0; l < LANES; l++) in_data[8*l +: 8] = nan_byte(in_fmt);
      cycle();
    end
    drain();
    chk("sat_nan", nan_cnt, 16'hFFFF);

    // Reset with both stages full
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin in_fmt = 1'($urandom); in_data = $urandom; cycle(); end
    chk("full_in_ready", in_ready, 0);
    in_valid = 1'b0; rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst2_ov", out_valid, 0);
    chk("rst2_ir", in_ready, 1);
    chk("rst2_nan", nan_cnt, 0);
    chk("rst2_data", out_data, 0);
    send_known("post_rst", 1'b1, 32'h017D7C3C, {32'h37800000, 32'h7FC00000, 32'h7F800000, 32'h3F800000});
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
